demux_param_nm: RTL and testbench

- Parametrised successor of the fixed 8->32 demux in the PCI physical-layer path.
- Collects RATIO consecutive valid IN_W-bit lanes into one OUT_W = IN_W*RATIO word.
- Runs on the single fast clock (clk_4f) and marks each completed word with a one-cycle strobe instead of using a slow clock.
- Adds a partial-word policy (pad or drop) and a saturating completed-word counter.

---
 rtl/demux_pkg.sv | 31 +++
 rtl/demux_lane_ctr.sv | 41 ++++
 rtl/demux_param_nm.sv | 148 ++++++++++++++
 tb/tb_demux_param_nm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared FSM encoding, clog2 helper and output-width macro for demux_param_nm
`ifndef DEMUX_PKG_SV
`define DEMUX_PKG_SV

// Width of an assembled output word: RATIO lanes of IN_W bits each.
`define DEMUX_OUT_W(in_w, ratio) ((in_w) * (ratio))

package demux_pkg;

    // IDLE: lane index is 0, no word in progress. COLLECT: 0 < idx < RATIO.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

`endif

// File: rtl/demux_lane_ctr.sv
// rtl/demux_lane_ctr.sv - lane index counter for demux_param_nm
module demux_lane_ctr
    import demux_pkg::*;
#(
    parameter int RATIO = 4,
    parameter int IDX_W = clog2(RATIO)
) (
    input  logic             clk_4f,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Clear wins over increment so a finished or abandoned word restarts at lane 0.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Lane index register.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == IDX_W'(RATIO - 1));

endmodule

// File: rtl/demux_param_nm.sv
// rtl/demux_param_nm.sv - collects RATIO input lanes into one wide word with pad/drop policy
module demux_param_nm
    import demux_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int RATIO       = 4,
    parameter int PAD_PARTIAL = 1,
    parameter int CNT_W       = 16
) (
    input  logic                                 clk_4f,
    input  logic                                 reset,
    input  logic [IN_W-1:0]                      data_in,
    input  logic                                 valid,
    output logic [`DEMUX_OUT_W(IN_W, RATIO)-1:0] data_out,
    output logic                                 valid_out,
    output logic                                 partial_out,
    output logic                                 drop_out,
    output logic [CNT_W-1:0]                     word_cnt
);

    localparam int OUT_W = `DEMUX_OUT_W(IN_W, RATIO);
    localparam int IDX_W = clog2(RATIO);

    state_t           state_q;
    state_t           state_d;
    logic [OUT_W-1:0] shreg_q;
    logic [OUT_W-1:0] shreg_d;
    logic [OUT_W-1:0] data_out_q;
    logic [OUT_W-1:0] data_out_d;
    logic             valid_out_q;
    logic             valid_out_d;
    logic             partial_out_q;
    logic             partial_out_d;
    logic             drop_out_q;
    logic             drop_out_d;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_d;

    logic             lane_inc;
    logic             lane_clr;
    logic [IDX_W-1:0] idx;
    logic             last;

    logic [OUT_W-1:0] shifted;
    logic [OUT_W-1:0] padded;
    logic [31:0]      pad_sh;

    demux_lane_ctr #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_lane_ctr (
        .clk_4f (clk_4f),
        .reset  (reset),
        .inc    (lane_inc),
        .clr    (lane_clr),
        .idx    (idx),
        .last   (last)
    );

    // The shift register is a full word wide; older lanes fall off the top, so
    // the low idx*IN_W bits always hold the lanes of the word in progress.
    assign shifted = {shreg_q[OUT_W-IN_W-1:0], data_in};

    // Left-align the idx collected lanes and zero-fill the missing ones.
    assign pad_sh  = 32'(OUT_W) - (32'(idx) * 32'(IN_W));
    assign padded  = shreg_q << pad_sh;

    // Next-state, shift and output decisions; strobes default low every cycle.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        data_out_d    = data_out_q;
        valid_out_d   = 1'b0;
        partial_out_d = 1'b0;
        drop_out_d    = 1'b0;
        word_cnt_d    = word_cnt_q;
        lane_inc      = 1'b0;
        lane_clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    shreg_d  = shifted;
                    lane_inc = 1'b1;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (valid && !last) begin
                    shreg_d  = shifted;
                    lane_inc = 1'b1;
                end else if (valid) begin
                    data_out_d  = shifted;
                    valid_out_d = 1'b1;
                    if (~&word_cnt_q) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    lane_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    if (PAD_PARTIAL != 0) begin
                        data_out_d    = padded;
                        valid_out_d   = 1'b1;
                        partial_out_d = 1'b1;
                    end else begin
                        drop_out_d = 1'b1;
                    end
                    lane_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register and registered outputs.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            shreg_q       <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            partial_out_q <= 1'b0;
            drop_out_q    <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            shreg_q       <= shreg_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            partial_out_q <= partial_out_d;
            drop_out_q    <= drop_out_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_out_q;
    assign partial_out = partial_out_q;
    assign drop_out    = drop_out_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_demux_param_nm.sv
// tb/tb_demux_param_nm.sv - self-checking bench for demux_param_nm
module tb_demux_param_nm;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: default (pad), B: same stream with drop policy
    logic        ab_rst;
    logic        ab_v;
    logic [7:0]  ab_d;
    logic [31:0] a_dout, b_dout;
    logic        a_vout, a_pout, a_drop, b_vout, b_pout, b_drop;
    logic [15:0] a_cnt, b_cnt;
    // C: IN_W=16 RATIO=2
    logic        c_rst, c_v;
    logic [15:0] c_d;
    logic [31:0] c_dout;
    logic        c_vout, c_pout, c_drop;
    logic [15:0] c_cnt;
    // D: IN_W=4 RATIO=8
    logic        d_rst, d_v;
    logic [3:0]  d_d;
    logic [31:0] d_dout;
    logic        d_vout, d_pout, d_drop;
    logic [15:0] d_cnt;
    // E: CNT_W=2
    logic        e_rst, e_v;
    logic [7:0]  e_d;
    logic [31:0] e_dout;
    logic        e_vout, e_pout, e_drop;
    logic [1:0]  e_cnt;

    demux_param_nm #(.IN_W(8), .RATIO(4), .PAD_PARTIAL(1), .CNT_W(16)) u_a (
        .clk_4f(clk), .reset(ab_rst), .data_in(ab_d), .valid(ab_v), .data_out(a_dout),
        .valid_out(a_vout), .partial_out(a_pout), .drop_out(a_drop), .word_cnt(a_cnt));
    demux_param_nm #(.IN_W(8), .RATIO(4), .PAD_PARTIAL(0), .CNT_W(16)) u_b (
        .clk_4f(clk), .reset(ab_rst), .data_in(ab_d), .valid(ab_v), .data_out(b_dout),
        .valid_out(b_vout), .partial_out(b_pout), .drop_out(b_drop), .word_cnt(b_cnt));
    demux_param_nm #(.IN_W(16), .RATIO(2), .PAD_PARTIAL(1), .CNT_W(16)) u_c (
        .clk_4f(clk), .reset(c_rst), .data_in(c_d), .valid(c_v), .data_out(c_dout),
        .valid_out(c_vout), .partial_out(c_pout), .drop_out(c_drop), .word_cnt(c_cnt));
    demux_param_nm #(.IN_W(4), .RATIO(8), .PAD_PARTIAL(1), .CNT_W(16)) u_d (
        .clk_4f(clk), .reset(d_rst), .data_in(d_d), .valid(d_v), .data_out(d_dout),
        .valid_out(d_vout), .partial_out(d_pout), .drop_out(d_drop), .word_cnt(d_cnt));
    demux_param_nm #(.IN_W(8), .RATIO(4), .PAD_PARTIAL(1), .CNT_W(2)) u_e (
        .clk_4f(clk), .reset(e_rst), .data_in(e_d), .valid(e_v), .data_out(e_dout),
        .valid_out(e_vout), .partial_out(e_pout), .drop_out(e_drop), .word_cnt(e_cnt));

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        ev;
        logic        ep;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [15:0] ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        partial;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                                input logic ev, input logic ep, input logic [31:0] ea,
                                input logic [31:0] eb, input logic [15:0] ecnt);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.ev = ev; r.ep = ep;
        r.ea = ea; r.eb = eb; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_word(input logic [7:0] base, input logic [1:0] exp_cnt, input int n);
        for (int k = 0; k < 4; k++) begin
            e_v = 1'b1;
            e_d = base + 8'(k);
            tick();
        end
        e_v = 1'b0;
        chk($sformatf("e_word%0d_vout", n), 32'(e_vout), 32'd1);
        chk($sformatf("e_word%0d_cnt", n), 32'(e_cnt), 32'(exp_cnt));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sb_t s;
        ab_rst = 1'b0; ab_v = 1'b0; ab_d = '0;
        c_rst = 1'b0; c_v = 1'b0; c_d = '0;
        d_rst = 1'b0; d_v = 1'b0; d_d = '0;
        e_rst = 1'b0; e_v = 1'b0; e_d = '0;
        tick();
        chk("rst_a_data", a_dout, 32'h0);
        chk("rst_a_strobes", {29'd0, a_vout, a_pout, a_drop}, 32'h0);
        chk("rst_a_cnt", 32'(a_cnt), 32'h0);
        chk("rst_b_strobes", {29'd0, b_vout, b_pout, b_drop}, 32'h0);
        chk("rst_c_data", c_dout, 32'h0);
        chk("rst_d_data", d_dout, 32'h0);
        chk("rst_e_cnt", 32'(e_cnt), 32'h0);

        // rst, v, d, ev, ep, exp A data, exp B data, exp count
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'hBB, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'hCC, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'hDD, 1, 0, 32'hAABBCCDD, 32'hAABBCCDD, 16'd1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 16'd1));
        vecs.push_back(mk(1, 1, 8'h01, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 16'd1));
        vecs.push_back(mk(1, 1, 8'h02, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 16'd1));
        vecs.push_back(mk(1, 1, 8'h03, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 16'd1));
        vecs.push_back(mk(1, 1, 8'h04, 1, 0, 32'h01020304, 32'h01020304, 16'd2));
        vecs.push_back(mk(1, 1, 8'h05, 0, 0, 32'h01020304, 32'h01020304, 16'd2));
        vecs.push_back(mk(1, 1, 8'h06, 0, 0, 32'h01020304, 32'h01020304, 16'd2));
        vecs.push_back(mk(1, 1, 8'h07, 0, 0, 32'h01020304, 32'h01020304, 16'd2));
        vecs.push_back(mk(1, 1, 8'h08, 1, 0, 32'h05060708, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 32'h05060708, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 1, 8'h11, 0, 0, 32'h05060708, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 1, 8'h22, 0, 0, 32'h05060708, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 0, 8'h00, 1, 1, 32'h11220000, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 32'h11220000, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 1, 8'h01, 0, 0, 32'h11220000, 32'h05060708, 16'd3));
        vecs.push_back(mk(1, 1, 8'h02, 0, 0, 32'h11220000, 32'h05060708, 16'd3));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'h0A, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'h0B, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'h0C, 0, 0, 32'h0,        32'h0,        16'd0));
        vecs.push_back(mk(1, 1, 8'h0D, 1, 0, 32'h0A0B0C0D, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 1, 8'h33, 0, 0, 32'h0A0B0C0D, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 0, 8'h00, 1, 1, 32'h33000000, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 1, 8'h44, 0, 0, 32'h33000000, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 1, 8'h55, 0, 0, 32'h33000000, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 1, 8'h66, 0, 0, 32'h33000000, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 0, 8'h00, 1, 1, 32'h44556600, 32'h0A0B0C0D, 16'd1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 32'h44556600, 32'h0A0B0C0D, 16'd1));

        for (int i = 0; i < vecs.size(); i++) begin
            ab_rst = vecs[i].rst;
            ab_v   = vecs[i].v;
            ab_d   = vecs[i].d;
            if (vecs[i].ev) begin
                s.data    = vecs[i].ea;
                s.partial = vecs[i].ep;
                sb_q.push_back(s);
            end
            tick();
            chk($sformatf("row%0d_a_vout", i), 32'(a_vout), 32'(vecs[i].ev));
            chk($sformatf("row%0d_a_pout", i), 32'(a_pout), 32'(vecs[i].ep));
            chk($sformatf("row%0d_a_drop", i), 32'(a_drop), 32'd0);
            chk($sformatf("row%0d_a_data", i), a_dout, vecs[i].ea);
            chk($sformatf("row%0d_a_cnt", i), 32'(a_cnt), 32'(vecs[i].ecnt));
            chk($sformatf("row%0d_b_vout", i), 32'(b_vout), 32'(vecs[i].ev & ~vecs[i].ep));
            chk($sformatf("row%0d_b_drop", i), 32'(b_drop), 32'(vecs[i].ev & vecs[i].ep));
            chk($sformatf("row%0d_b_pout", i), 32'(b_pout), 32'd0);
            chk($sformatf("row%0d_b_data", i), b_dout, vecs[i].eb);
            chk($sformatf("row%0d_b_cnt", i), 32'(b_cnt), 32'(vecs[i].ecnt));
            if (a_vout) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("row%0d_sb_unexpected", i), 32'd1, 32'd0);
                end else begin
                    s = sb_q.pop_front();
                    chk($sformatf("row%0d_sb_data", i), a_dout, s.data);
                    chk($sformatf("row%0d_sb_partial", i), 32'(a_pout), 32'(s.partial));
                end
            end
        end
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);

        // IN_W=16, RATIO=2
        c_rst = 1'b1;
        c_v = 1'b1; c_d = 16'h1234;
        tick();
        chk("c_first_vout", 32'(c_vout), 32'd0);
        c_d = 16'h5678;
        tick();
        chk("c_word_data", c_dout, 32'h12345678);
        chk("c_word_vout", 32'(c_vout), 32'd1);
        chk("c_word_pout", 32'(c_pout), 32'd0);
        chk("c_word_cnt", 32'(c_cnt), 32'd1);
        c_v = 1'b0;
        tick();
        chk("c_strobe_low", 32'(c_vout), 32'd0);
        chk("c_hold", c_dout, 32'h12345678);
        c_v = 1'b1; c_d = 16'h9ABC;
        tick();
        c_v = 1'b0;
        tick();
        chk("c_pad_data", c_dout, 32'h9ABC0000);
        chk("c_pad_pout", 32'(c_pout), 32'd1);
        chk("c_pad_cnt", 32'(c_cnt), 32'd1);

        // IN_W=4, RATIO=8
        d_rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d_v = 1'b1;
            d_d = 4'(k);
            tick();
            chk($sformatf("d_lane%0d_vout", k), 32'(d_vout), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("d_word_data", d_dout, 32'h12345678);
        chk("d_word_cnt", 32'(d_cnt), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            d_d = 4'(k);
            tick();
        end
        d_v = 1'b0;
        tick();
        chk("d_pad_data", d_dout, 32'h12300000);
        chk("d_pad_pout", 32'(d_pout), 32'd1);
        chk("d_pad_cnt", 32'(d_cnt), 32'd1);

        // CNT_W=2 saturation, with a padded word that must not count
        e_rst = 1'b1;
        e_word(8'h10, 2'd1, 1);
        chk("e_word1_data", e_dout, 32'h10111213);
        e_v = 1'b1; e_d = 8'h77;
        tick();
        e_v = 1'b0;
        tick();
        chk("e_pad_pout", 32'(e_pout), 32'd1);
        chk("e_pad_cnt", 32'(e_cnt), 32'd1);
        e_word(8'h20, 2'd2, 2);
        e_word(8'h30, 2'd3, 3);
        e_word(8'h40, 2'd3, 4);
        e_word(8'h50, 2'd3, 5);
        chk("e_last_data", e_dout, 32'h50515253);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
